mmio_rsp_mux: RTL and testbench
===============================

// Module: mmio_rsp_mux
// PURPOSE
//  Return path of the MMIO bus: takes the one-hot enables from the address decoder, tracks the
//  outstanding CPU access, and returns read data or a write ack. Sources are RAM, LEDs,
//  7-seg LCD and buttons. RAM reads are variable-latency and guarded by a timeout.
//  Unmapped or multiply-selected addresses return an error.
//  Sits between the CPU load/store unit and the decoder-selected slaves; one access in flight.
// PARAMETERS
//  DATA_W          32            width of read data / response bus
//  TIMEOUT_CYCLES  16            max WAIT cycles for ram_rvalid_i before error (>=1)
//  ERR_DATA        32'hDEADBEEF  rsp_rdata_o value on any error response
// PORTS
//  clk_i            in   1       clock, all logic on rising edge
//  rst_i            in   1       synchronous active-high reset
//  req_valid_i      in   1       CPU access request valid
//  req_ready_o      out  1       block can accept a request
//  req_we_i         in   1       1 = write, 0 = read
//  en_ram_i         in   1       decoder enable, RAM
//  en_leds_i        in   1       decoder enable, LEDs
//  en_7_seg_lcd_i   in   1       decoder enable, 7-seg LCD
//  en_buttons_i     in   1       decoder enable, buttons
//  ram_rdata_i      in   DATA_W  RAM read data, valid with ram_rvalid_i
//  ram_rvalid_i     in   1       RAM read data valid (1-cycle pulse)
//  leds_rdata_i     in   DATA_W  LED register readback, combinational
//  seg_rdata_i      in   DATA_W  7-seg register readback, combinational
//  buttons_rdata_i  in   DATA_W  button state, combinational
//  rsp_valid_o      out  1       response valid
//  rsp_rdata_o      out  DATA_W  read data (0 on write ack, ERR_DATA on error)
//  rsp_err_o        out  1       response is an error
//  rsp_ready_i      in   1       CPU consumes response
// BEHAVIOUR
//  States: IDLE, WAIT, RESP. On reset: state = IDLE, counter = 0, rsp_valid_o = 0,
//   rsp_err_o = 0, rsp_rdata_o = 0. req_ready_o = 1 iff state == IDLE. Reset mid-access drops it; no rsp.
//  Accept = req_valid_i & req_ready_o in IDLE; the enables are sampled in the accept cycle only.
//  Classify at accept (popcount of the four enables):
//   - 0 or >1 enables set: go to RESP with rsp_err_o = 1 and rsp_rdata_o = ERR_DATA (read or write).
//   - write, exactly one enable set: go to RESP with rsp_err_o = 0 and rsp_rdata_o = 0.
//   - read from LEDs/7-seg/buttons: capture the selected *_rdata_i in the accept cycle -> RESP, err=0.
//   - read from RAM: go to WAIT and clear the counter.
//  Latency: accept in cycle N -> rsp_valid_o = 1 in N+1, for all cases except RAM read.
//  WAIT: ram_rvalid_i = 1 in cycle M -> capture ram_rdata_i -> RESP with err = 0, rsp_valid_o in M+1.
//   - Otherwise the counter increments each cycle.
//   - When the counter == TIMEOUT_CYCLES-1 and there is no rvalid: go to RESP with err = 1, ERR_DATA.
//   - rvalid on the final counted cycle wins over the timeout.
//  ram_rvalid_i is ignored outside WAIT. A late pulse after a timeout is dropped and must not
//   corrupt the next access.
//  Counter width = $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
//  RESP: rsp_valid_o, rsp_rdata_o and rsp_err_o are registered and held stable until rsp_ready_i = 1.
//   - On the handshake cycle: go to IDLE; rsp_valid_o = 0 next cycle; rdata and err are cleared to 0.
//   - Back-to-back: a new request can be accepted in the cycle after the handshake (1 idle-ready cycle).
//  req_valid_i is ignored while req_ready_o = 0.
// TESTING
//  1 Read buttons: en_buttons_i = 1, buttons_rdata_i = 32'h5, accept at N
//    -> N+1: rsp_valid_o = 1, rdata = 32'h5, err = 0.
//  2 RAM read: ram_rvalid_i = 1 with rdata 32'hCAFE0001 three cycles after accept
//    -> rsp_valid_o one cycle later, data matches, err = 0.
//  3 RAM timeout (TIMEOUT_CYCLES = 16): no rvalid -> err = 1, rdata = 32'hDEADBEEF,
//    rsp_valid_o 17 cycles after accept; a late rvalid is ignored.
//  4 Unmapped: all enables 0, read -> N+1: err = 1, ERR_DATA.
//    Two enables set on a write -> same error response.
//  5 Backpressure: hold rsp_ready_i = 0 for 5 cycles
//    -> rsp outputs stable and req_ready_o = 0 throughout; ack in cycle K -> req_ready_o = 1 at K+1.
//  6 Reset: assert rst_i while in WAIT -> next cycle state is IDLE, all outputs 0, req_ready_o = 1,
//    no response emitted.

Source files
------------

// File: rtl/mmio_rsp_mux.sv
// MMIO return path: tracks the single outstanding CPU access and produces a read-data,
// write-ack or error response from the decoder-selected slave.
module mmio_rsp_mux #(
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(32'hDEADBEEF)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic              en_ram_i,
    input  logic              en_leds_i,
    input  logic              en_7_seg_lcd_i,
    input  logic              en_buttons_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_rvalid_i,
    input  logic [DATA_W-1:0] leds_rdata_i,
    input  logic [DATA_W-1:0] seg_rdata_i,
    input  logic [DATA_W-1:0] buttons_rdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    input  logic              rsp_ready_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [2:0]        sel_cnt;

    assign sel_cnt = 3'(en_ram_i) + 3'(en_leds_i) + 3'(en_7_seg_lcd_i) + 3'(en_buttons_i);

    // Next-state and response payload
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (sel_cnt != 3'd1) begin
                        state_d = ST_RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = ERR_DATA;
                    end else if (req_we_i) begin
                        state_d = ST_RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                        rdata_d = '0;
                    end else if (en_ram_i) begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                        if (en_leds_i) begin
                            rdata_d = leds_rdata_i;
                        end else if (en_7_seg_lcd_i) begin
                            rdata_d = seg_rdata_i;
                        end else begin
                            rdata_d = buttons_rdata_i;
                        end
                    end
                end
            end
            ST_WAIT: begin
                // rvalid on the last counted cycle takes priority over the timeout
                if (ram_rvalid_i) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = ram_rdata_i;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                err_d   = 1'b0;
                rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = valid_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_mmio_rsp_mux.sv
// Scoreboard bench for mmio_rsp_mux: expected responses are queued at issue time and
// compared (data, error flag, latency, handshake cleanup) when the response appears.
module tb_mmio_rsp_mux;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic        en_ram_i;
    logic        en_leds_i;
    logic        en_7_seg_lcd_i;
    logic        en_buttons_i;
    logic [31:0] ram_rdata_i;
    logic        ram_rvalid_i;
    logic [31:0] leds_rdata_i;
    logic [31:0] seg_rdata_i;
    logic [31:0] buttons_rdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_ready_i;

    exp_t exp_q[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   accept_cyc = 0;

    always #5 clk_i = ~clk_i;

    mmio_rsp_mux #(.DATA_W(32), .TIMEOUT_CYCLES(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_we_i        (req_we_i),
        .en_ram_i        (en_ram_i),
        .en_leds_i       (en_leds_i),
        .en_7_seg_lcd_i  (en_7_seg_lcd_i),
        .en_buttons_i    (en_buttons_i),
        .ram_rdata_i     (ram_rdata_i),
        .ram_rvalid_i    (ram_rvalid_i),
        .leds_rdata_i    (leds_rdata_i),
        .seg_rdata_i     (seg_rdata_i),
        .buttons_rdata_i (buttons_rdata_i),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_rdata_o     (rsp_rdata_o),
        .rsp_err_o       (rsp_err_o),
        .rsp_ready_i     (rsp_ready_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // en = {ram, leds, seg, buttons}
    task automatic issue(input string name, input logic we, input logic [3:0] en,
                         input logic push, input logic [31:0] d, input logic e);
        exp_t t;
        req_valid_i = 1'b1;
        req_we_i    = we;
        {en_ram_i, en_leds_i, en_7_seg_lcd_i, en_buttons_i} = en;
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_at_issue: got %b want 1", name, req_ready_o);
        end
        if (push) begin
            t.data = d;
            t.err  = e;
            exp_q.push_back(t);
        end
        step();
        accept_cyc  = cyc - 1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        {en_ram_i, en_leds_i, en_7_seg_lcd_i, en_buttons_i} = 4'b0000;
    endtask

    task automatic collect(input string name, input int exp_lat);
        exp_t t;
        int   lat;
        while (rsp_valid_o !== 1'b1 && (cyc - accept_cyc) < 40) step();
        lat = cyc - accept_cyc;
        checks++;
        if (rsp_valid_o !== 1'b1 || lat != exp_lat) begin
            failures++;
            $display("FAIL %s_latency: valid=%b lat=%0d want valid=1 lat=%0d", name, rsp_valid_o, lat, exp_lat);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s_scoreboard: got empty queue want one entry", name);
        end else begin
            t = exp_q.pop_front();
            checks++;
            if (rsp_rdata_o !== t.data) begin
                failures++;
                $display("FAIL %s_rdata: got %h want %h", name, rsp_rdata_o, t.data);
            end
            checks++;
            if (rsp_err_o !== t.err) begin
                failures++;
                $display("FAIL %s_err: got %b want %b", name, rsp_err_o, t.err);
            end
        end
        checks++;
        if (req_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_in_resp: got %b want 0", name, req_ready_o);
        end
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL %s_after_ack: got valid=%b rdata=%h err=%b ready=%b want 0/0/0/1",
                     name, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got valid=%b rdata=%h err=%b ready=%b want 0/0/0/1",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
        end
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_periph_reads();
        issue("rd_buttons", 1'b0, 4'b0001, 1'b1, 32'h0000_0005, 1'b0);
        collect("rd_buttons", 1);
        issue("rd_leds", 1'b0, 4'b0100, 1'b1, 32'h1111_00AA, 1'b0);
        collect("rd_leds", 1);
        issue("rd_seg", 1'b0, 4'b0010, 1'b1, 32'h0000_7E7E, 1'b0);
        collect("rd_seg", 1);
    endtask

    task automatic test_ram_read();
        issue("ram_rd", 1'b0, 4'b1000, 1'b1, 32'hCAFE_0001, 1'b0);
        step();
        step();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'hCAFE_0001;
        step();
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = 32'h0;
        collect("ram_rd", 4);
        // rvalid on the last counted WAIT cycle must beat the timeout
        issue("ram_last", 1'b0, 4'b1000, 1'b1, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 15; i++) step();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'h1234_5678;
        step();
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = 32'h0;
        collect("ram_last", 17);
    endtask

    task automatic test_timeout();
        issue("ram_to", 1'b0, 4'b1000, 1'b1, 32'hDEAD_BEEF, 1'b1);
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (rsp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL ram_to_early: got valid=%b want 0 at 16 cycles", rsp_valid_o);
        end
        step();
        ram_rvalid_i = 1'b1;
        ram_rdata_i  = 32'h0BAD_0BAD;
        step();
        ram_rvalid_i = 1'b0;
        collect("ram_to", 18);
        ram_rvalid_i = 1'b1;
        step();
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = 32'h0;
        issue("after_to", 1'b0, 4'b0001, 1'b1, 32'h0000_0005, 1'b0);
        collect("after_to", 1);
    endtask

    task automatic test_errors();
        issue("unmapped_rd", 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b1);
        collect("unmapped_rd", 1);
        issue("multi_wr", 1'b1, 4'b0110, 1'b1, 32'hDEAD_BEEF, 1'b1);
        collect("multi_wr", 1);
        issue("all_rd", 1'b0, 4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b1);
        collect("all_rd", 1);
        issue("wr_leds", 1'b1, 4'b0100, 1'b1, 32'h0, 1'b0);
        collect("wr_leds", 1);
        issue("wr_ram", 1'b1, 4'b1000, 1'b1, 32'h0, 1'b0);
        collect("wr_ram", 1);
    endtask

    task automatic test_backpressure();
        logic ok;
        ok = 1'b1;
        issue("bp", 1'b0, 4'b0100, 1'b1, 32'h1111_00AA, 1'b0);
        leds_rdata_i = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            req_valid_i  = 1'b1;
            en_buttons_i = 1'b1;
            if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h1111_00AA || rsp_err_o !== 1'b0 || req_ready_o !== 1'b0)
                ok = 1'b0;
            step();
        end
        req_valid_i  = 1'b0;
        en_buttons_i = 1'b0;
        leds_rdata_i = 32'h1111_00AA;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_hold: got unstable rsp or ready=1 want held 1/111100aa/0 ready=0");
        end
        collect("bp", 6);
    endtask

    task automatic test_back_to_back();
        issue("b2b_0", 1'b0, 4'b0001, 1'b1, 32'h0000_0005, 1'b0);
        collect("b2b_0", 1);
        issue("b2b_1", 1'b0, 4'b0010, 1'b1, 32'h0000_7E7E, 1'b0);
        collect("b2b_1", 1);
        issue("b2b_2", 1'b1, 4'b0001, 1'b1, 32'h0, 1'b0);
        collect("b2b_2", 1);
    endtask

    task automatic test_reset_mid();
        logic quiet;
        quiet = 1'b1;
        issue("rst_mid", 1'b0, 4'b1000, 1'b0, 32'h0, 1'b0);
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        checks++;
        if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_state: got valid=%b rdata=%h err=%b ready=%b want 0/0/0/1",
                     rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
        end
        for (int i = 0; i < 25; i++) begin
            ram_rvalid_i = (i == 3);
            ram_rdata_i  = 32'h5555_AAAA;
            if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) quiet = 1'b0;
            step();
        end
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = 32'h0;
        checks++;
        if (!quiet) begin
            failures++;
            $display("FAIL rst_mid_quiet: got a response or busy after reset want none");
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
        end
    endtask

    initial begin
        rst_i           = 1'b1;
        req_valid_i     = 1'b0;
        req_we_i        = 1'b0;
        en_ram_i        = 1'b0;
        en_leds_i       = 1'b0;
        en_7_seg_lcd_i  = 1'b0;
        en_buttons_i    = 1'b0;
        ram_rdata_i     = 32'h0;
        ram_rvalid_i    = 1'b0;
        leds_rdata_i    = 32'h1111_00AA;
        seg_rdata_i     = 32'h0000_7E7E;
        buttons_rdata_i = 32'h0000_0005;
        rsp_ready_i     = 1'b0;
        test_reset();
        test_periph_reads();
        test_ram_read();
        test_timeout();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
